// File: rtl/ls_err_cnt_array.sv
// ls_err_cnt_array: multi-channel DUT error counter with START/STOP run window.
// Each channel's CREST_IN bit passes through a MAX_DLY-deep delay line. The tap
// chosen by DLY_SEL is compared with the shared expected bit RPG_IN. Mismatches
// are counted per channel while in RUN. The first failing channel and cycle are
// captured.
// Build option: define LS_CNT_SAT_EN to make the counters saturate. By default
// they wrap. OVF is sticky in both modes.
module ls_err_cnt_array #(
   parameter  int N_CH    = 4,
   parameter  int CNT_W   = 32,
   parameter  int MAX_DLY = 3,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              CLK,
   input  logic              RST_PER,
   input  logic [N_CH-1:0]   CREST_IN,
   input  logic              RPG_IN,
   input  logic [2:0]        DLY_SEL,
   input  logic              START,
   input  logic              STOP,
   input  logic              CLR_CNT,
   input  logic [CH_W-1:0]   RD_SEL,
   output logic [N_CH-1:0]   COMP_OUT,
   output logic [CNT_W-1:0]  ERR_CNT_RD,
   output logic [CNT_W-1:0]  CYC_CNT,
   output logic [N_CH-1:0]   OVF,
   output logic              FIRST_ERR_VLD,
   output logic [CH_W-1:0]   FIRST_ERR_CH,
   output logic [CNT_W-1:0]  FIRST_ERR_CYC,
   output logic [1:0]        STATE
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam int               ACNT_W  = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ACNT_W-1:0] r_arm_cnt;
   logic [ACNT_W-1:0] w_arm_cnt_nxt;
   logic [N_CH-1:0]   r_dly [MAX_DLY];
   logic [CNT_W-1:0]  r_err [N_CH];
   logic [CNT_W-1:0]  r_cyc;
   logic [CNT_W-1:0]  r_rd;
   logic [CNT_W-1:0]  r_first_cyc;
   logic [N_CH-1:0]   r_ovf;
   logic              r_first_vld;
   logic [CH_W-1:0]   r_first_ch;
   logic [3:0]        w_dly_eff;
   logic [N_CH-1:0]   w_sample;
   logic [N_CH-1:0]   w_cmp;
   logic [CH_W-1:0]   w_low_ch;
   logic              w_clr;
   logic              w_run;

   // Counter step: holds at all-ones when saturating, otherwise rolls over to 0.
   function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
`ifdef LS_CNT_SAT_EN
      f_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
`else
      f_inc = v + CNT_W'(1);
`endif
   endfunction

   // A START that leaves IDLE opens a fresh run. It clears the counters just
   // like CLR_CNT does. STOP in the same cycle suppresses that START.
   assign w_clr = CLR_CNT || ((r_state == ST_IDLE) && START && !STOP);
   assign w_run = (r_state == ST_RUN);

   // Clamp DLY_SEL to 1..MAX_DLY, then pick that delay-line tap.
   always_comb begin
      if (DLY_SEL == 3'd0)
         w_dly_eff = 4'd1;
      else if ({1'b0, DLY_SEL} > 4'(MAX_DLY))
         w_dly_eff = 4'(MAX_DLY);
      else
         w_dly_eff = {1'b0, DLY_SEL};
      w_sample = '0;
      for (int k = 0; k < MAX_DLY; k++)
         if (w_dly_eff == 4'(k + 1)) w_sample = r_dly[k];
   end

   assign w_cmp    = w_sample ^ {N_CH{RPG_IN}};
   assign COMP_OUT = w_cmp;

   // Lowest-index mismatching channel, used for the first-error capture.
   always_comb begin
      w_low_ch = '0;
      for (int c = N_CH - 1; c >= 0; c--)
         if (w_cmp[c]) w_low_ch = CH_W'(c);
   end

   // Sample delay line: shifts every cycle regardless of FSM state.
   always_ff @(posedge CLK) begin
      if (RST_PER) begin
         for (int k = 0; k < MAX_DLY; k++) r_dly[k] <= '0;
      end else begin
         r_dly[0] <= CREST_IN;
         for (int k = 1; k < MAX_DLY; k++) r_dly[k] <= r_dly[k-1];
      end
   end

   // FSM state register plus the ARM settle counter.
   always_ff @(posedge CLK) begin
      if (RST_PER) begin
         r_state   <= ST_IDLE;
         r_arm_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_arm_cnt <= w_arm_cnt_nxt;
      end
   end

   // Next-state logic. ARM lasts MAX_DLY cycles, which flushes pre-START
   // samples out of the delay line. STOP has priority over START.
   always_comb begin
      w_state_nxt   = r_state;
      w_arm_cnt_nxt = r_arm_cnt;
      case (r_state)
         ST_IDLE, ST_HOLD: begin
            if (START && !STOP) begin
               w_state_nxt   = ST_ARM;
               w_arm_cnt_nxt = '0;
            end
         end
         ST_ARM: begin
            if (STOP)
               w_state_nxt = ST_HOLD;
            else if (r_arm_cnt == ACNT_W'(MAX_DLY - 1))
               w_state_nxt = ST_RUN;
            else
               w_arm_cnt_nxt = r_arm_cnt + ACNT_W'(1);
         end
         ST_RUN: begin
            if (STOP) w_state_nxt = ST_HOLD;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Per-channel error counters, run-cycle counter, OVF and first-error capture.
   // A clear takes priority over any increment in the same cycle.
   always_ff @(posedge CLK) begin
      if (RST_PER || w_clr) begin
         for (int c = 0; c < N_CH; c++) r_err[c] <= '0;
         r_cyc       <= '0;
         r_ovf       <= '0;
         r_first_vld <= 1'b0;
         r_first_ch  <= '0;
         r_first_cyc <= '0;
      end else if (w_run) begin
         r_cyc <= f_inc(r_cyc);
         for (int c = 0; c < N_CH; c++) begin
            if (w_cmp[c]) begin
               r_err[c] <= f_inc(r_err[c]);
               if (r_err[c] == CNT_MAX) r_ovf[c] <= 1'b1;
            end
         end
         if (!r_first_vld && (|w_cmp)) begin
            r_first_vld <= 1'b1;
            r_first_ch  <= w_low_ch;
            r_first_cyc <= r_cyc;
         end
      end
   end

   // Registered readout. A channel index with no counter behind it reads 0.
   always_ff @(posedge CLK) begin
      if (RST_PER) begin
         r_rd <= '0;
      end else begin
         r_rd <= '0;
         for (int c = 0; c < N_CH; c++)
            if (RD_SEL == CH_W'(c)) r_rd <= r_err[c];
      end
   end

   assign ERR_CNT_RD    = r_rd;
   assign CYC_CNT       = r_cyc;
   assign OVF           = r_ovf;
   assign FIRST_ERR_VLD = r_first_vld;
   assign FIRST_ERR_CH  = r_first_ch;
   assign FIRST_ERR_CYC = r_first_cyc;
   assign STATE         = r_state;

endmodule
